mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the data (load/store) requester. It arbitrates between them, registers the winner's command onto the memory port, waits for the memory's grant and response, and routes the response back to the owner. Exactly one transaction is outstanding at a time. The block sits between the fetch/LSU stages and the unified memory interface.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch command accepted by memory
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  byte enables
- d_gnt  out  1  data command accepted by memory
- d_rvalid  out  1  data response valid; stores also receive a response
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  command valid to memory
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered command
- mem_gnt  in  1  memory accepts command while mem_req=1
- mem_rvalid  in  1  memory response; never in the same cycle as its mem_gnt
- mem_rdata  in  DATA_WIDTH  response data

## Operation
- States: ST_IDLE, ST_REQ, ST_RSP. The owner register holds OWN_IF or OWN_D.
- ST_IDLE:
  - If any request is pending, pick the owner and latch its command into the mem_* registers.
  - A fetch latches mem_we=0, mem_be=all ones, mem_wdata=0.
  - Next state is ST_REQ.
  - With no request pending, stay in ST_IDLE.
- ST_REQ:
  - mem_req=1 and the command is held stable.
  - On mem_gnt, the owner's gnt is asserted combinationally in the same cycle, and the block goes to ST_RSP with mem_req=0 in the next cycle.
- ST_RSP:
  - On mem_rvalid, the owner's rvalid is asserted combinationally and the block goes to ST_IDLE.
  - if_rdata and d_rdata are both wired directly to mem_rdata; each is meaningful only while its rvalid is high.
- Default priority: data wins a tie, because the load/store belongs to an older instruction.
- Boundary cases:
  - mem_rvalid outside ST_RSP is ignored and routed to neither requester.
  - A requester may present a new request in the cycle after its rvalid; it is arbitrated in ST_IDLE.
  - Dropping req before gnt is a protocol violation; the block continues the latched transaction regardless.
  - A rst asserted mid-transaction forces ST_IDLE and clears the mem_* registers. Any in-flight response is then dropped per the ST_IDLE rule.

## Timing
- Reset values:
  - State ST_IDLE, owner OWN_IF, last-owner OWN_IF.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be = 0.
  - if_gnt, d_gnt, if_rvalid, d_rvalid = 0.
- Request sampled in ST_IDLE at cycle N -> mem_req=1 at N+1.
- mem_gnt at cycle G -> x_gnt=1 at G; ST_RSP from G+1.
- Earliest mem_rvalid is at G+1 -> x_rvalid that same cycle; ST_IDLE at G+2.
- Minimum occupancy is 3 cycles per transaction. Peak throughput is therefore one transaction per 3 cycles.
- gnt and rvalid are single-cycle pulses per transaction.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data over fetch.
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, grant the requester that was not the most recent owner.
  - last_owner updates when an arbitration occurs in ST_IDLE. It resets to OWN_IF, so the first tie goes to data.
  - Non-tie behaviour is identical in both modes.

## Structure
- Package mem_arb_pkg:
  - state_t enum {ST_IDLE, ST_REQ, ST_RSP}.
  - owner_t enum {OWN_IF, OWN_D}.
- Sub-module mem_arb_pick: combinational winner selection from if_req, d_req and last_owner. The ARB_ROUND_ROBIN_EN logic lives here.
- The top level holds the FSM, the command registers, and the response/grant routing.

## Test plan
- Single fetch: if_req=1, if_addr=0x100; mem_gnt after 2 cycles; mem_rvalid 1 cycle later with 0xDEADBEEF -> mem_addr=0x100, mem_we=0, mem_be=0xF; if_gnt pulses; if_rvalid=1 with if_rdata=0xDEADBEEF; d_* stay 0.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x55, d_be=0x1 -> mem_* match after 1 cycle; d_gnt, then d_rvalid on the response; if_gnt never asserts.
- Tie, default build: if_req and d_req both 1 for two back-to-back transactions -> data is served first, and is served again while d_req remains asserted.
- Tie with ARB_ROUND_ROBIN_EN: both continuously requesting for 4 transactions -> owners alternate D, IF, D, IF.
- Spurious and late responses: mem_rvalid in ST_IDLE and ST_REQ -> no rvalid on either requester. rst asserted in ST_RSP -> mem_req=0 next cycle, state ST_IDLE; a following mem_rvalid is ignored.
- Memory stall: mem_gnt held low for 10 cycles -> mem_req and the command stay stable; neither gnt asserts until mem_gnt.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state and owner encodings for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data requesters
// Build option: ARB_ROUND_ROBIN_EN selects alternating tie-break instead of data-first.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
   input  logic last_owner,
   output logic any_req,
   output logic pick_d
);

   assign any_req = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
   // on a tie, hand the port to whoever did not own it last
   assign pick_d = d_req & (~if_req | (last_owner != logic'(OWN_D)));
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
   // data belongs to an older instruction, so it always wins a tie
   assign pick_d = d_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, one transaction outstanding
// Build option: ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   state_t state;
   owner_t owner;
   owner_t last_owner;
   logic   any_req;
   logic   pick_d;

   mem_arb_pick u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_owner (last_owner == OWN_D),
      .any_req    (any_req),
      .pick_d     (pick_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_IF;
         last_owner <= OWN_IF;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner      <= pick_d ? OWN_D : OWN_IF;
                  last_owner <= pick_d ? OWN_D : OWN_IF;
                  mem_req    <= 1'b1;
                  state      <= ST_REQ;
                  if (pick_d) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_be    <= d_be;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_be    <= '1;
                  end
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (mem_rvalid) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // handshakes are routed in the same cycle; responses outside ST_RSP go nowhere
   assign if_gnt    = (state == ST_REQ) && mem_gnt && (owner == OWN_IF);
   assign d_gnt     = (state == ST_REQ) && mem_gnt && (owner == OWN_D);
   assign if_rvalid = (state == ST_RSP) && mem_rvalid && (owner == OWN_IF);
   assign d_rvalid  = (state == ST_RSP) && mem_rvalid && (owner == OWN_D);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized transaction-level checks of mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int tests = 0;
   int failed = 0;

   // reference model: pending requests and their held commands
   bit          p_if, p_d, last_d;
   logic [31:0] m_if_addr, m_d_addr, m_d_wdata;
   logic        m_d_we;
   logic [3:0]  m_d_be;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_if(input logic [31:0] a);
      p_if = 1; m_if_addr = a;
      if_req = 1; if_addr = a;
   endtask

   task automatic start_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
      p_d = 1; m_d_we = we; m_d_addr = a; m_d_wdata = wd; m_d_be = be;
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
   endtask

   task automatic chk_cmd(input bit wd);
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, wd ? m_d_we : 1'b0);
      chk("mem_addr", mem_addr, wd ? m_d_addr : m_if_addr);
      chk("mem_wdata", mem_wdata, wd ? m_d_wdata : 32'h0);
      chk("mem_be", mem_be, wd ? m_d_be : 4'hF);
   endtask

   // one full transaction starting in an idle cycle with at least one request pending
   task automatic run_txn(input int stall, input int lat, input bit spur, input logic [31:0] rd);
      bit wd;
      if (p_if && p_d) begin
`ifdef ARB_ROUND_ROBIN_EN
         wd = !last_d;
`else
         wd = 1;
`endif
      end else begin
         wd = p_d;
      end
      mem_rvalid = spur;
      @(negedge clk);
      chk("idle_if_rvalid", if_rvalid, 0);
      chk("idle_d_rvalid", d_rvalid, 0);
      chk("idle_mem_req", mem_req, 0);
      tick();
      mem_rvalid = 0;
      last_d = wd;
      for (int i = 0; i < stall; i++) begin
         mem_gnt = 0;
         mem_rvalid = spur && (i == 0);
         @(negedge clk);
         chk_cmd(wd);
         chk("stall_if_gnt", if_gnt, 0);
         chk("stall_d_gnt", d_gnt, 0);
         chk("req_if_rvalid", if_rvalid, 0);
         chk("req_d_rvalid", d_rvalid, 0);
         tick();
      end
      mem_rvalid = 0;
      mem_gnt = 1;
      @(negedge clk);
      chk_cmd(wd);
      chk("if_gnt", if_gnt, !wd);
      chk("d_gnt", d_gnt, wd);
      tick();
      mem_gnt = 0;
      if (wd) begin
         p_d = 0; d_req = 0; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom; d_be = $urandom;
      end else begin
         p_if = 0; if_req = 0; if_addr = $urandom;
      end
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         chk("rsp_mem_req", mem_req, 0);
         chk("rsp_gnts", {if_gnt, d_gnt}, 2'b00);
         chk("wait_rvalid", {if_rvalid, d_rvalid}, 2'b00);
         tick();
      end
      mem_rvalid = 1;
      mem_rdata = rd;
      @(negedge clk);
      chk("if_rvalid", if_rvalid, !wd);
      chk("d_rvalid", d_rvalid, wd);
      chk("rdata", wd ? d_rdata : if_rdata, rd);
      tick();
      mem_rvalid = 0;
   endtask

   initial begin
      rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      p_if = 0; p_d = 0; last_d = 0;
      m_if_addr = 0; m_d_addr = 0; m_d_wdata = 0; m_d_we = 0; m_d_be = 0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_gnts", {if_gnt, d_gnt}, 2'b00);
      chk("rst_rvalids", {if_rvalid, d_rvalid}, 2'b00);
      tick();
      rst = 0; mem_gnt = 0; mem_rvalid = 0;

      // single fetch, then a store
      start_if(32'h100);
      run_txn(2, 0, 1, 32'hDEADBEEF);
      start_d(1, 32'h2004, 32'h55, 4'h1);
      run_txn(0, 0, 0, 32'h0);

      // continuous tie over four transactions
      for (int k = 0; k < 4; k++) begin
         if (!p_if) start_if($urandom);
         if (!p_d) start_d($urandom, $urandom, $urandom, 4'($urandom));
         run_txn(0, 0, 0, $urandom);
      end
      if (p_if) run_txn(0, 0, 0, $urandom);
      if (p_d) run_txn(0, 0, 0, $urandom);

      // memory stall
      start_if(32'hABC0);
      run_txn(10, 2, 1, 32'hC0FFEE00);

      // reset while waiting for the response
      start_d(0, 32'h3000, 32'h0, 4'hF);
      @(negedge clk);
      tick();
      mem_gnt = 1;
      @(negedge clk);
      chk("rstx_d_gnt", d_gnt, 1);
      tick();
      mem_gnt = 0; p_d = 0; d_req = 0;
      rst = 1;
      @(negedge clk);
      chk("rstx_no_rvalid", {if_rvalid, d_rvalid}, 2'b00);
      tick();
      rst = 0; last_d = 0;
      mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("rstx_mem_req", mem_req, 0);
      chk("rstx_mem_addr", mem_addr, 0);
      chk("rstx_mem_be", mem_be, 0);
      chk("rstx_late_rvalid", {if_rvalid, d_rvalid}, 2'b00);
      tick();
      mem_rvalid = 0;
      @(negedge clk);
      chk("rstx_idle", mem_req, 0);
      tick();

      // randomized traffic
      for (int k = 0; k < 80; k++) begin
         if (!p_if && !p_d && ($urandom % 4 == 0)) begin
            mem_rvalid = $urandom;
            @(negedge clk);
            chk("rand_idle_rvalid", {if_rvalid, d_rvalid}, 2'b00);
            tick();
            mem_rvalid = 0;
            @(negedge clk);
            chk("rand_idle_req", mem_req, 0);
            tick();
         end
         if (!p_if && ($urandom % 2 == 1)) start_if($urandom);
         if (!p_d && ($urandom % 2 == 1)) start_d($urandom, $urandom, $urandom, 4'($urandom));
         if (!p_if && !p_d) begin
            if ($urandom % 2 == 1) start_if($urandom);
            else start_d($urandom, $urandom, $urandom, 4'($urandom));
         end
         run_txn($urandom_range(0, 4), $urandom_range(0, 3), $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
